// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl
//   Scans an N x N image with a 3x3 window. It reads one pixel column of a
//   3-row band per cycle and flags the cycles on which a complete window
//   reaches the datapath.
//
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : single-cycle scan request; size and filter sampled with it
//   size[7:0]      : image side N (3..255 accepted)
//   filter[7:0]    : filter select, latched onto filter_sel on accept
//   stall          : freezes address generation while in RUN
//   rd_en          : column read strobe; rows row_addr..row_addr+2, column col_addr
//   row_addr[7:0]  : top row of the current band
//   col_addr[7:0]  : column being read
//   validData      : a full window is at the datapath (one cycle after its read)
//   res_addr       : output pixel address of that window
//   filter_sel     : latched filter select
//   busy           : scan in progress (RUN or DRAIN)
//   done           : end-of-scan pulse, coincident with the last validData
//   size_err       : one-cycle pulse after a start with size < 3
module window_scan_ctrl #(
    parameter int RES_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       size,
    input  logic [7:0]       filter,
    input  logic             stall,
    output logic             rd_en,
    output logic [7:0]       row_addr,
    output logic [7:0]       col_addr,
    output logic             validData,
    output logic [RES_W-1:0] res_addr,
    output logic [7:0]       filter_sel,
    output logic             busy,
    output logic             done,
    output logic             size_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       n_reg;
    logic [RES_W-1:0] out_cnt;
    logic             accept;
    logic             reject;
    logic             last_col;
    logic             last_row;
    logic             last_rd;
    logic             win_rd;

    assign accept   = (state == IDLE) && start && (size >= 8'd3);
    assign reject   = (state == IDLE) && start && (size < 8'd3);
    assign last_col = (col_addr == (n_reg - 8'd1));
    assign last_row = (row_addr == (n_reg - 8'd3));
    assign last_rd  = rd_en && last_col && last_row;
    // Reads of columns 0 and 1 only prime the window; later reads complete one.
    assign win_rd   = rd_en && (col_addr >= 8'd2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)  state_nxt = RUN;
            RUN:     if (last_rd) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state)
            IDLE:  ;
            RUN: begin
                rd_en = !stall;
                busy  = 1'b1;
            end
            DRAIN: begin
                // The last read completes its window during this one cycle.
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Address counters, window pipeline and latched configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg      <= '0;
            filter_sel <= '0;
            row_addr   <= '0;
            col_addr   <= '0;
            validData  <= 1'b0;
            res_addr   <= '0;
            out_cnt    <= '0;
            size_err   <= 1'b0;
        end else begin
            size_err  <= reject;
            // One-cycle memory latency: the window flag trails its read by one.
            validData <= win_rd;
            // Windows emerge in raster order, so a running count equals
            // row*(N-2) + (col-2) without a multiplier.
            if (win_rd) begin
                res_addr <= out_cnt;
                out_cnt  <= out_cnt + 1'b1;
            end

            if (accept) begin
                n_reg      <= size;
                filter_sel <= filter;
                row_addr   <= '0;
                col_addr   <= '0;
                out_cnt    <= '0;
            end else if (rd_en && !last_rd) begin
                if (last_col) begin
                    col_addr <= '0;
                    row_addr <= row_addr + 8'd1;
                end else begin
                    col_addr <= col_addr + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameter: RES_W, default 16, width of res_addr.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  single-cycle request to begin one image scan.
REQ-005 size  in  8  image side N (square N x N), sampled with start.
REQ-006 filter  in  8  filter select, sampled with start.
REQ-007 stall  in  1  freezes address generation while high.
REQ-008 rd_en  out  1  pixel-column read strobe to line memory.
REQ-009 row_addr  out  8  top row of current 3-row band; memory returns rows row_addr..row_addr+2.
REQ-010 col_addr  out  8  column being read.
REQ-011 validData  out  1  datapath window-valid strobe.
REQ-012 res_addr  out  RES_W  output pixel address of the window marked by validData.
REQ-013 filter_sel  out  8  latched filter select.
REQ-014 busy  out  1  scan in progress.
REQ-015 done  out  1  single-cycle end-of-scan pulse.
REQ-016 size_err  out  1  single-cycle pulse on rejected start.

Function
REQ-017 States: IDLE, RUN, DRAIN; IDLE->RUN on accepted start; RUN->DRAIN after last read issues; DRAIN->IDLE after one cycle.
REQ-018 Start is accepted only in IDLE with 3 <= size <= 255; accepting latches N=size and filter_sel=filter.
REQ-019 start with size < 3 in IDLE: no state change; size_err high the next cycle for one cycle.
REQ-020 start while busy: ignored; no latch and no size_err.
REQ-021 busy is high in RUN and DRAIN.
REQ-022 The first rd_en is the cycle after start is accepted, with row_addr=0 and col_addr=0.
REQ-023 Each non-stalled RUN cycle: rd_en=1; col_addr increments; at col N-1 it wraps to 0 and row_addr increments, with no idle gap between bands.
REQ-024 The last read is row_addr=N-3, col_addr=N-1; total reads = (N-2)*N.
REQ-025 stall=1 in RUN: rd_en=0; row/col counters hold; stall has no effect in IDLE or DRAIN.
REQ-026 Memory latency is fixed at 1 cycle, so the data for a read is at the datapath the cycle after rd_en.
REQ-027 validData is high exactly the cycle after a read with col_addr >= 2, and low after reads of columns 0 and 1 of every band.
REQ-028 res_addr during validData = row*(N-2) + (col-2) of the originating read, computed at RES_W bits without overflow for N <= 255.
REQ-029 Reads still in flight when stall rises still produce validData and res_addr on schedule.
REQ-030 done pulses coincident with the final validData, in DRAIN; busy falls the next cycle.
REQ-031 Total validData pulses per scan = (N-2)^2; res_addr values run 0..(N-2)^2-1 in increasing order.
REQ-032 start coincident with the done cycle is ignored; start is accepted from the following IDLE cycle.

Reset
REQ-033 rst_n low immediately forces IDLE, mid-scan included, with outputs: rd_en=0, row_addr=0, col_addr=0, validData=0, res_addr=0, filter_sel=0, busy=0, done=0, size_err=0.
REQ-034 rst_n low discards any in-flight validData.
REQ-035 After rst_n rises, the block waits for a new start.

Verification
REQ-036 N=3, filter=5: start -> 3 reads (cols 0,1,2, row 0); one validData with res_addr=0, coincident with done; filter_sel=5.
REQ-037 N=4: 8 reads; validData res_addr 0,1 (band 0) then 2,3 (band 1); validData low on the cycle after row-1 col-0 and col-1 reads; done with res_addr=3.
REQ-038 N=5, stall high 2 cycles after the read of row 0 col 3: counters hold for 2 cycles; the col-3 window (res_addr=1) still emits; 9 total validData; sequence unbroken.
REQ-039 size=2 start -> size_err pulse, busy stays 0, no rd_en; then a second start with size=3 runs normally.
REQ-040 N=6, rst_n low after 10 reads -> all outputs 0 at once; no further validData; a new start with N=3 completes correctly.
REQ-041 start pulses during a busy N=4 scan -> ignored; filter_sel unchanged; exactly 4 validData.
